uart_tx_frame: RTL and testbench

// - UART transmit framer, the TX counterpart of the RX deserialiser path.
// - Accepts a DATA-bit parallel word and serialises it on TX_OUT, one bit per CLK cycle (CLK = baud clock).
// - Frame format: start(0), data LSB first, optional parity, stop(1).
// - Sits between the TX async FIFO read side and the UART pad.

---
 rtl/uart_tx_frame.sv | 150 +++++++++++++++
 tb/tb_uart_tx_frame.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, DATA bits LSB first, optional parity, stop bit; one bit per CLK.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_frame #(
  parameter int unsigned DATA = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [DATA-1:0] P_DATA,
  input  logic            DATA_VALID,
  input  logic            PAR_EN,
  input  logic            PAR_TYP,
  output logic            TX_OUT,
  output logic            Busy
);

  localparam int unsigned CW = $clog2(DATA + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DATA-1:0] shadow_q, shadow_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic [CW-1:0]   cnt_inc_c;
  logic            next_bit_c;

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_en_d;
  logic par_typ_q, par_typ_d;
  logic par_bit_c;
  assign par_bit_c = par_typ_q ? ~(^shadow_q) : (^shadow_q);
`else
  logic unused_par_c;
  assign unused_par_c = PAR_EN ^ PAR_TYP;
`endif

  // Select shadow bit by a counter value without a width-mismatched index
  function automatic logic pick_bit(input logic [DATA-1:0] w, input logic [CW-1:0] idx);
    logic b;
    b = 1'b0;
    for (int unsigned i = 0; i < DATA; i++) begin
      if (idx == CW'(i)) b = w[i];
    end
    return b;
  endfunction

  assign cnt_inc_c  = cnt_q + CW'(1);
  assign next_bit_c = pick_bit(shadow_q, cnt_inc_c);

  // Next state; TX_OUT is loaded with the bit belonging to the next state
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
`ifdef UART_TX_PARITY_EN
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
`endif
    case (state_q)
      S_IDLE, S_STOP: begin
        if (DATA_VALID) begin
          state_d  = S_START;
          shadow_d = P_DATA;
`ifdef UART_TX_PARITY_EN
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
`endif
          tx_d     = 1'b0;
          busy_d   = 1'b1;
        end else begin
          state_d = S_IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      end
      S_START: begin
        state_d = S_DATA;
        cnt_d   = '0;
        tx_d    = shadow_q[0];
      end
      S_DATA: begin
        cnt_d = cnt_inc_c;
        if (cnt_q == CW'(DATA - 1)) begin
`ifdef UART_TX_PARITY_EN
          if (par_en_q) begin
            state_d = S_PARITY;
            tx_d    = par_bit_c;
          end else begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end
`else
          state_d = S_STOP;
          tx_d    = 1'b1;
`endif
        end else begin
          tx_d = next_bit_c;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        state_d = S_STOP;
        tx_d    = 1'b1;
      end
`endif
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
`endif
    end
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: a frame-level model pushes expected line bits into a queue at accept,
// and a negedge monitor pops and compares TX_OUT/Busy every cycle (idle expected when empty).
module tb_uart_tx_frame;

  localparam int unsigned DATA = 8;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic [DATA-1:0] P_DATA = '0;
  logic            DATA_VALID = 1'b0;
  logic            PAR_EN = 1'b0;
  logic            PAR_TYP = 1'b0;
  logic            TX_OUT;
  logic            Busy;

  int n_cmp = 0;
  int n_err = 0;
  logic exp_q[$];

  uart_tx_frame #(.DATA(DATA)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .TX_OUT(TX_OUT), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Expected line sequence for one frame, built from the frame format
  function automatic void push_frame(input logic [DATA-1:0] d, input logic pe, input logic pt);
    int ones;
    ones = 0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < int'(DATA); i++) begin
      exp_q.push_back(d[i]);
      ones += int'(d[i]);
    end
`ifdef UART_TX_PARITY_EN
    // even: bit makes total ones even; odd: bit makes total ones odd
    if (pe) exp_q.push_back(pt ? ((ones % 2) == 0) : ((ones % 2) == 1));
`else
    if (pe && pt && ones < 0) exp_q.push_back(1'b0);
`endif
    exp_q.push_back(1'b1);
  endfunction

  // Model: a request is taken whenever the line has no bits left to send after the current one
  always @(posedge CLK or negedge RST) begin
    if (!RST) exp_q.delete();
    else if (DATA_VALID && exp_q.size() == 0) push_frame(P_DATA, PAR_EN, PAR_TYP);
  end

  // Monitor
  always @(negedge CLK) begin
    logic eb, ebusy;
    if (exp_q.size() > 0) begin
      eb = exp_q.pop_front();
      ebusy = 1'b1;
    end else begin
      eb = 1'b1;
      ebusy = 1'b0;
    end
    chk("tx_line", TX_OUT, eb);
    chk("busy", Busy, ebusy);
  end

  task automatic send(input logic [DATA-1:0] d, input logic pe, input logic pt);
    @(negedge CLK);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; DATA_VALID = 1'b1;
    @(negedge CLK);
    DATA_VALID = 1'b0;
  endtask

  // Wait until the stop bit is on the line (no bits pending), bounded
  task automatic wait_drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      @(negedge CLK);
      #1;
      k++;
    end
    chk("drain_timeout", exp_q.size() == 0, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    // Reset with random inputs
    #1 RST = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      P_DATA = DATA'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
      DATA_VALID = 1'($urandom);
    end
    #1;
    chk("reset_tx", TX_OUT, 1'b1);
    chk("reset_busy", Busy, 1'b0);
    DATA_VALID = 1'b0;
    #1 RST = 1'b1;
    idle(20);

    // 8N1 0xA5
    send(8'hA5, 1'b0, 1'b0);
    wait_drain();
    idle(3);

    // Parity cases (plain 10-bit frames when parity is compiled out)
    send(8'hA5, 1'b1, 1'b0); wait_drain(); idle(2);
    send(8'hA5, 1'b1, 1'b1); wait_drain(); idle(2);
    send(8'h07, 1'b1, 1'b0); wait_drain(); idle(2);

    // Back-to-back through STOP-state accept
    send(8'h55, 1'b0, 1'b0);
    wait_drain();
    P_DATA = 8'h0F; PAR_EN = 1'b0; DATA_VALID = 1'b1;
    @(negedge CLK);
    DATA_VALID = 1'b0;
    wait_drain();
    idle(3);

    // Mid-frame noise on inputs during DATA
    send(8'h3C, 1'b1, 1'b0);
    repeat (4) begin
      @(negedge CLK);
      P_DATA = DATA'($urandom); PAR_TYP = ~PAR_TYP; PAR_EN = 1'($urandom);
      DATA_VALID = ~DATA_VALID;
    end
    @(negedge CLK);
    DATA_VALID = 1'b0;
    wait_drain();
    idle(3);

    // Abort in data bit 4
    send(8'h3C, 1'b0, 1'b0);
    repeat (5) @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    chk("abort_tx", TX_OUT, 1'b1);
    chk("abort_busy", Busy, 1'b0);
    idle(2);
    #1 RST = 1'b1;
    idle(2);
    send(8'hC3, 1'b1, 1'b1);
    wait_drain();
    idle(3);

    // Randomised requests, including STOP-state accepts and ignored mid-frame requests
    repeat (600) begin
      @(negedge CLK);
      P_DATA = DATA'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
      DATA_VALID = ($urandom_range(0, 3) == 0);
    end
    @(negedge CLK);
    DATA_VALID = 1'b0;
    wait_drain();
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
